// File: rtl/prml_agc_slicer.sv
// prml_agc_slicer
//   Digital AGC, 10-bit sample reduction and ternary slicer between the
//   adaptive equalizer and the PRML decoder. Each accepted sample is scaled by
//   an unsigned Q2.6 gain, shifted down by 8, saturated to SAMPLE_WIDTH and
//   sliced against thresholds derived from three tracked PR4 target levels.
//   The gain is adjusted once per WINDOW output samples from the window peak.
//
// Ports
//   clk, reset_n      clock, asynchronous active-low reset
//   enable, freeze    block enable; hold gain/levels/window counters
//   data_in/valid     signed equalized sample and its strobe
//   sample_out/valid  signed scaled sample, valid 2 cycles after data_valid
//   decision_out      00 = 0, 01 = +2, 11 = -2
//   level_*           tracked -2 / 0 / +2 levels
//   gain, locked      current AGC gain (Q2.6) and lock flag
//   state             00 IDLE, 01 ACQUIRE, 10 TRACK
module prml_agc_slicer #(
  parameter int DATA_WIDTH   = 12,
  parameter int SAMPLE_WIDTH = 10,
  parameter int TARGET       = 256,
  parameter int DEADBAND     = 16,
  parameter int GAIN_INIT    = 64,
  parameter int WINDOW       = 32,
  parameter int LOCK_WINDOWS = 4,
  parameter int LEVEL_SHIFT  = 4
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           enable,
  input  logic                           freeze,
  input  logic signed [DATA_WIDTH-1:0]   data_in,
  input  logic                           data_valid,
  output logic signed [SAMPLE_WIDTH-1:0] sample_out,
  output logic                           sample_valid,
  output logic [1:0]                     decision_out,
  output logic signed [SAMPLE_WIDTH-1:0] level_neg2,
  output logic signed [SAMPLE_WIDTH-1:0] level_zero,
  output logic signed [SAMPLE_WIDTH-1:0] level_pos2,
  output logic [7:0]                     gain,
  output logic                           locked,
  output logic [1:0]                     state
);

  localparam int PROD_W = DATA_WIDTH + 9;
  localparam int LVL_W  = SAMPLE_WIDTH + 1;
  localparam int CNT_W  = $clog2(WINDOW);
  localparam int LCK_W  = $clog2(LOCK_WINDOWS + 1);

  localparam logic signed [PROD_W-1:0] SAT_MAX = PROD_W'((2 ** (SAMPLE_WIDTH - 1)) - 1);
  localparam logic signed [PROD_W-1:0] SAT_MIN = PROD_W'(-(2 ** (SAMPLE_WIDTH - 1)));
  localparam logic [LVL_W-1:0] PK_HI  = LVL_W'(TARGET + DEADBAND);
  localparam logic [LVL_W-1:0] PK_LO  = LVL_W'(TARGET - DEADBAND);
  localparam logic [LVL_W-1:0] FAR_HI = LVL_W'(TARGET + 2 * DEADBAND);
  localparam logic [LVL_W-1:0] FAR_LO = LVL_W'(TARGET - 2 * DEADBAND);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(WINDOW - 1);
  localparam logic [LCK_W-1:0] LOCK_LAST = LCK_W'(LOCK_WINDOWS - 1);

  typedef enum logic [1:0] {S_IDLE = 2'b00, S_ACQ = 2'b01, S_TRACK = 2'b10} state_t;

  function automatic logic signed [SAMPLE_WIDTH-1:0] sat_sample(input logic signed [PROD_W-1:0] v);
    if (v > SAT_MAX)      return SAT_MAX[SAMPLE_WIDTH-1:0];
    else if (v < SAT_MIN) return SAT_MIN[SAMPLE_WIDTH-1:0];
    else                  return v[SAMPLE_WIDTH-1:0];
  endfunction

  function automatic logic [7:0] clamp_gain(input logic signed [9:0] g);
    if (g < 10'sd16)       return 8'd16;
    else if (g > 10'sd255) return 8'd255;
    else                   return g[7:0];
  endfunction

  logic signed [PROD_W-1:0]       prod_p1_q, prod_p1_d;
  logic                           vld_p1_q, vld_p1_d;
  logic signed [SAMPLE_WIDTH-1:0] sample_p2_q, sample_p2_d;
  logic [1:0]                     dec_p2_q, dec_p2_d;
  logic                           vld_p2_q, vld_p2_d;
  logic signed [SAMPLE_WIDTH-1:0] lvl_neg_q, lvl_neg_d, lvl_zero_q, lvl_zero_d, lvl_pos_q, lvl_pos_d;
  logic [7:0]                     gain_q, gain_d;
  state_t                         state_q, state_d;
  logic                           locked_q, locked_d;
  logic [CNT_W-1:0]               win_cnt_q, win_cnt_d;
  logic [LVL_W-1:0]               peak_q, peak_d, win_peak_q, win_peak_d;
  logic [LCK_W-1:0]               lock_cnt_q, lock_cnt_d;
  logic                           eval_q, eval_d;

  logic signed [PROD_W-1:0]       din_ext, gain_ext;
  logic signed [SAMPLE_WIDTH-1:0] s_sat, lvl_sel;
  logic signed [LVL_W-1:0]        s_ext, sum_hi, sum_lo, thr_hi, thr_lo, diff, lvl_sum;
  logic signed [SAMPLE_WIDTH-1:0] lvl_new;
  logic [1:0]                     dec_s;
  logic [LVL_W-1:0]               abs_s, peak_new;
  logic                           accept, take, upd, win_hi, win_lo, win_far;
  logic signed [9:0]              g_ext, g_step;

  always_comb begin
    // Stage 1: multiply accepted sample by the current gain
    accept    = data_valid && enable && (state_q != S_IDLE);
    din_ext   = PROD_W'(data_in);
    gain_ext  = PROD_W'({1'b0, gain_q});
    vld_p1_d  = accept;
    prod_p1_d = accept ? (din_ext * gain_ext) : prod_p1_q;

    // Stage 2: scale, saturate, slice and track levels
    take   = vld_p1_q && enable;
    upd    = take && !freeze;
    s_sat  = sat_sample(prod_p1_q >>> 8);
    s_ext  = LVL_W'(s_sat);
    sum_hi = LVL_W'(lvl_zero_q) + LVL_W'(lvl_pos_q);
    sum_lo = LVL_W'(lvl_neg_q) + LVL_W'(lvl_zero_q);
    thr_hi = sum_hi >>> 1;
    thr_lo = sum_lo >>> 1;
    if (s_ext >= thr_hi)    dec_s = 2'b01;
    else if (s_ext < thr_lo) dec_s = 2'b11;
    else                    dec_s = 2'b00;
    case (dec_s)
      2'b01:   lvl_sel = lvl_pos_q;
      2'b11:   lvl_sel = lvl_neg_q;
      default: lvl_sel = lvl_zero_q;
    endcase
    diff     = s_ext - LVL_W'(lvl_sel);
    lvl_sum  = LVL_W'(lvl_sel) + (diff >>> LEVEL_SHIFT);
    lvl_new  = sat_sample(PROD_W'(lvl_sum));
    abs_s    = s_ext[LVL_W-1] ? LVL_W'(-s_ext) : LVL_W'(s_ext);
    peak_new = (abs_s > peak_q) ? abs_s : peak_q;

    vld_p2_d    = take;
    sample_p2_d = take ? s_sat : sample_p2_q;
    dec_p2_d    = take ? dec_s : dec_p2_q;
    lvl_neg_d   = lvl_neg_q;
    lvl_zero_d  = lvl_zero_q;
    lvl_pos_d   = lvl_pos_q;
    peak_d      = peak_q;
    win_cnt_d   = win_cnt_q;
    win_peak_d  = win_peak_q;
    eval_d      = 1'b0;
    if (upd) begin
      case (dec_s)
        2'b01:   lvl_pos_d  = lvl_new;
        2'b11:   lvl_neg_d  = lvl_new;
        default: lvl_zero_d = lvl_new;
      endcase
      // The WINDOW-th sample closes the window: its peak is handed to the
      // evaluator and the accumulators restart for the next window.
      if (win_cnt_q == CNT_LAST) begin
        eval_d     = 1'b1;
        win_peak_d = peak_new;
        peak_d     = '0;
        win_cnt_d  = '0;
      end else begin
        peak_d    = peak_new;
        win_cnt_d = win_cnt_q + CNT_W'(1);
      end
    end

    // Stage 3: window evaluation, gain and state update
    win_hi  = win_peak_q > PK_HI;
    win_lo  = win_peak_q < PK_LO;
    win_far = (win_peak_q > FAR_HI) || (win_peak_q < FAR_LO);
    g_ext   = $signed({2'b00, gain_q});
    g_step  = (state_q == S_TRACK) ? 10'sd1 : 10'sd4;
    gain_d     = gain_q;
    state_d    = state_q;
    locked_d   = locked_q;
    lock_cnt_d = lock_cnt_q;
    if (!enable) begin
      state_d    = S_IDLE;
      locked_d   = 1'b0;
      lock_cnt_d = '0;
      win_cnt_d  = '0;
      peak_d     = '0;
      eval_d     = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_ACQ;
        S_ACQ, S_TRACK: begin
          if (eval_q && !freeze) begin
            if (win_hi)      gain_d = clamp_gain(g_ext - g_step);
            else if (win_lo) gain_d = clamp_gain(g_ext + g_step);
            if (state_q == S_ACQ) begin
              if (win_hi || win_lo) begin
                lock_cnt_d = '0;
              end else if (lock_cnt_q == LOCK_LAST) begin
                state_d    = S_TRACK;
                locked_d   = 1'b1;
                lock_cnt_d = '0;
              end else begin
                lock_cnt_d = lock_cnt_q + LCK_W'(1);
              end
            end else if (win_far) begin
              state_d    = S_ACQ;
              locked_d   = 1'b0;
              lock_cnt_d = '0;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prod_p1_q   <= '0;
      vld_p1_q    <= 1'b0;
      sample_p2_q <= '0;
      dec_p2_q    <= 2'b00;
      vld_p2_q    <= 1'b0;
      lvl_neg_q   <= SAMPLE_WIDTH'(-TARGET);
      lvl_zero_q  <= '0;
      lvl_pos_q   <= SAMPLE_WIDTH'(TARGET);
      gain_q      <= 8'(GAIN_INIT);
      state_q     <= S_IDLE;
      locked_q    <= 1'b0;
      win_cnt_q   <= '0;
      peak_q      <= '0;
      win_peak_q  <= '0;
      lock_cnt_q  <= '0;
      eval_q      <= 1'b0;
    end else begin
      prod_p1_q   <= prod_p1_d;
      vld_p1_q    <= vld_p1_d;
      sample_p2_q <= sample_p2_d;
      dec_p2_q    <= dec_p2_d;
      vld_p2_q    <= vld_p2_d;
      lvl_neg_q   <= lvl_neg_d;
      lvl_zero_q  <= lvl_zero_d;
      lvl_pos_q   <= lvl_pos_d;
      gain_q      <= gain_d;
      state_q     <= state_d;
      locked_q    <= locked_d;
      win_cnt_q   <= win_cnt_d;
      peak_q      <= peak_d;
      win_peak_q  <= win_peak_d;
      lock_cnt_q  <= lock_cnt_d;
      eval_q      <= eval_d;
    end
  end

  assign sample_out   = sample_p2_q;
  assign sample_valid = vld_p2_q;
  assign decision_out = dec_p2_q;
  assign level_neg2   = lvl_neg_q;
  assign level_zero   = lvl_zero_q;
  assign level_pos2   = lvl_pos_q;
  assign gain         = gain_q;
  assign locked       = locked_q;
  assign state        = state_q;

endmodule

// File: tb/tb_prml_agc_slicer.sv
// Testbench for prml_agc_slicer: directed phases (latency, acquisition, loss
// of lock, saturation, enable drop, async reset) plus randomized traffic,
// compared every cycle against a behavioural model built from the block's
// arithmetic and window rules.
module tb_prml_agc_slicer;

  localparam int WINDOW = 32;
  localparam int LOCK_WINDOWS = 4;
  localparam int TARGET = 256;
  localparam int DEADBAND = 16;

  logic clk = 1'b0;
  logic reset_n, enable, freeze, data_valid;
  logic signed [11:0] data_in;
  logic signed [9:0] sample_out, level_neg2, level_zero, level_pos2;
  logic sample_valid, locked;
  logic [1:0] decision_out, state;
  logic [7:0] gain;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  prml_agc_slicer dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .freeze(freeze),
    .data_in(data_in), .data_valid(data_valid),
    .sample_out(sample_out), .sample_valid(sample_valid), .decision_out(decision_out),
    .level_neg2(level_neg2), .level_zero(level_zero), .level_pos2(level_pos2),
    .gain(gain), .locked(locked), .state(state)
  );

  // ---------------- reference model ----------------
  int m_gain, m_neg, m_zero, m_pos, m_state, m_locked, m_lock_cnt, m_cnt, m_peak;
  bit inf_v; int inf_din, inf_g;
  bit pend_v; int pend_pk;
  bit e_v; int e_s, e_code;

  function automatic int sat10(int v);
    return (v > 511) ? 511 : ((v < -512) ? -512 : v);
  endfunction

  function automatic int scale(int din, int g);
    return sat10((din * g) >>> 8);
  endfunction

  function automatic int track(int l, int s);
    return sat10(l + ((s - l) >>> 4));
  endfunction

  task automatic model_reset();
    m_gain = 64; m_neg = -TARGET; m_zero = 0; m_pos = TARGET;
    m_state = 0; m_locked = 0; m_lock_cnt = 0; m_cnt = 0; m_peak = 0;
    inf_v = 0; inf_din = 0; inf_g = 0; pend_v = 0; pend_pk = 0;
    e_v = 0; e_s = 0; e_code = 0;
  endtask

  // One clock edge of the block as seen from outside.
  task automatic model_step(bit en, bit frz, bit dv, int din);
    int st0, old_pk, s, th, tl, code, a, step, dev;
    bit old_pv, inband;
    st0 = m_state; old_pv = pend_v; old_pk = pend_pk; pend_v = 0;
    if (!en) begin
      inf_v = 0; e_v = 0; m_state = 0; m_locked = 0; m_lock_cnt = 0;
      m_cnt = 0; m_peak = 0;
      return;
    end
    e_v = inf_v;
    if (inf_v) begin
      s = scale(inf_din, inf_g);
      th = (m_zero + m_pos) >>> 1;
      tl = (m_neg + m_zero) >>> 1;
      if (s >= th) code = 1; else if (s < tl) code = 3; else code = 0;
      e_s = s; e_code = code;
      if (!frz) begin
        if (code == 1) m_pos = track(m_pos, s);
        else if (code == 3) m_neg = track(m_neg, s);
        else m_zero = track(m_zero, s);
        a = (s < 0) ? -s : s;
        if (a > m_peak) m_peak = a;
        m_cnt++;
        if (m_cnt == WINDOW) begin
          pend_v = 1; pend_pk = m_peak; m_cnt = 0; m_peak = 0;
        end
      end
    end
    inf_v = dv && (st0 != 0); inf_din = din; inf_g = m_gain;
    if (st0 == 0) begin
      m_state = 1;
    end else if (old_pv && !frz) begin
      step = (m_state == 2) ? 1 : 4;
      inband = 1;
      if (old_pk > TARGET + DEADBAND) begin
        m_gain = (m_gain - step < 16) ? 16 : m_gain - step; inband = 0;
      end else if (old_pk < TARGET - DEADBAND) begin
        m_gain = (m_gain + step > 255) ? 255 : m_gain + step; inband = 0;
      end
      if (m_state == 1) begin
        if (!inband) m_lock_cnt = 0;
        else begin
          m_lock_cnt++;
          if (m_lock_cnt == LOCK_WINDOWS) begin
            m_state = 2; m_locked = 1; m_lock_cnt = 0;
          end
        end
      end else begin
        dev = (old_pk > TARGET) ? old_pk - TARGET : TARGET - old_pk;
        if (dev > 2 * DEADBAND) begin
          m_state = 1; m_locked = 0; m_lock_cnt = 0;
        end
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("sample_valid", sample_valid, e_v);
    if (e_v) begin
      chk("sample_out", sample_out, e_s);
      chk("decision_out", decision_out, e_code);
    end
    chk("gain", gain, m_gain);
    chk("state", state, m_state);
    chk("locked", locked, m_locked);
    chk("level_pos2", level_pos2, m_pos);
    chk("level_neg2", level_neg2, m_neg);
    chk("level_zero", level_zero, m_zero);
  endtask

  task automatic cyc(bit en, bit frz, bit dv, int din);
    logic [31:0] dv32;
    dv32 = din;
    enable = en; freeze = frz; data_valid = dv; data_in = dv32[11:0];
    @(posedge clk);
    model_step(en, frz, dv, din);
    #1;
    check_all();
  endtask

  function automatic int pm(int a);
    return ($urandom_range(0, 1) == 1) ? a : -a;
  endfunction

  task automatic directed(int din, int exp_s, int exp_d);
    cyc(1, 1, 1, din);
    chk("lat_no_early_valid", sample_valid, 1'b0);
    cyc(1, 1, 0, 0);
    chk("lat_valid", sample_valid, 1'b1);
    chk("lat_sample", sample_out, exp_s);
    chk("lat_decision", decision_out, exp_d);
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b0; freeze = 1'b0; data_valid = 1'b0; data_in = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gain", gain, 64);
    chk("rst_pos2", level_pos2, 256);
    chk("rst_neg2", level_neg2, -256);
    chk("rst_zero", level_zero, 0);
    chk("rst_valid", sample_valid, 1'b0);
    chk("rst_locked", locked, 1'b0);
    chk("rst_state", state, 0);
    reset_n = 1'b1;

    // Latency and scaling with gain 1.0, frozen
    cyc(1, 1, 0, 0);
    chk("idle_to_acq", state, 1);
    directed(1024, 256, 1);
    directed(-2048, -512, 3);
    directed(100, 25, 0);

    // Acquisition from +-512
    for (int i = 0; i < 18 * WINDOW; i++) cyc(1, 0, 1, pm(512));
    repeat (3) cyc(1, 0, 0, 0);
    chk("acq_gain", gain, 120);
    chk("acq_state", state, 2);
    chk("acq_locked", locked, 1'b1);

    // Loss of lock with +-128 input
    for (int i = 0; i < WINDOW; i++) cyc(1, 0, 1, pm(128));
    repeat (3) cyc(1, 0, 0, 0);
    chk("lol_state", state, 1);
    chk("lol_locked", locked, 1'b0);
    chk("lol_gain", gain, 121);
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < WINDOW; i++) cyc(1, 0, 1, pm(128));
      repeat (3) cyc(1, 0, 0, 0);
    end
    chk("reacq_gain", gain, 129);

    // Saturation at gain 129
    cyc(1, 1, 1, 2047);
    cyc(1, 1, 0, 0);
    chk("sat_pos", sample_out, 511);
    cyc(1, 1, 1, -2048);
    cyc(1, 1, 0, 0);
    chk("sat_neg", sample_out, -512);

    // Enable drop mid-window
    for (int i = 0; i < 10; i++) cyc(1, 0, 1, pm(128));
    cyc(0, 0, 0, 0);
    chk("drop_valid", sample_valid, 1'b0);
    chk("drop_state", state, 0);
    chk("drop_gain", gain, 129);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("reen_state", state, 1);
    for (int i = 0; i < WINDOW - 1; i++) cyc(1, 0, 1, pm(128));
    repeat (3) cyc(1, 0, 0, 0);
    chk("win31_gain", gain, 129);
    cyc(1, 0, 1, pm(128));
    cyc(1, 0, 0, 0);
    chk("win32_gain_hold", gain, 129);
    cyc(1, 0, 0, 0);
    chk("win32_gain_step", gain, 133);

    // Randomized traffic: full-range data, gaps, freeze and enable drops
    for (int i = 0; i < 600; i++)
      cyc(($urandom_range(0, 49) != 0), ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 3) != 0), int'($urandom_range(0, 4095)) - 2048);

    // Asynchronous reset in the middle of a window
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 0, 1, pm(512));
    #2 reset_n = 1'b0;
    #1;
    chk("arst_gain", gain, 64);
    chk("arst_state", state, 0);
    chk("arst_valid", sample_valid, 1'b0);
    chk("arst_pos2", level_pos2, 256);
    model_reset();
    @(posedge clk);
    #1 reset_n = 1'b1;
    cyc(1, 0, 0, 0);
    for (int i = 0; i < WINDOW - 1; i++) cyc(1, 0, 1, pm(512));
    repeat (2) cyc(1, 0, 0, 0);
    chk("arst_win31_gain", gain, 64);
    cyc(1, 0, 1, pm(512));
    repeat (2) cyc(1, 0, 0, 0);
    chk("arst_win32_gain", gain, 68);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/prml_agc_slicer.md
Name: prml_agc_slicer

Overview:
- Sits between adaptive_equalizer and the PRML decoder in the DSP chain.
- Takes the 12-bit equalized stream and applies digital AGC, giving a fixed nominal amplitude.
- Reduces and saturates the stream to the 10-bit PRML sample width.
- Makes a ternary (-2/0/+2) tentative decision on each sample and tracks the three PR4 target levels that the PRML decoder consumes.

Parameters:
- DATA_WIDTH, 12, equalizer sample width (signed).
- SAMPLE_WIDTH, 10, PRML sample width (signed).
- TARGET, 256, nominal |+2|/|-2| level at output.
- DEADBAND, 16, AGC in-band tolerance around TARGET.
- GAIN_INIT, 64, reset gain. Gain is unsigned Q2.6, so 64 = 1.0.
- WINDOW, 32, valid samples per AGC peak window (power of 2).
- LOCK_WINDOWS, 4, consecutive in-band windows required to lock.
- LEVEL_SHIFT, 4, level tracker IIR shift.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  block enable
- freeze  in  1  hold gain and levels
- data_in  in  DATA_WIDTH  signed equalized sample
- data_valid  in  1  sample strobe
- sample_out  out  SAMPLE_WIDTH  signed scaled sample
- sample_valid  out  1  output strobe
- decision_out  out  2  tentative symbol: 00=0, 01=+2, 11=-2
- level_neg2  out  SAMPLE_WIDTH  tracked -2 level
- level_zero  out  SAMPLE_WIDTH  tracked 0 level
- level_pos2  out  SAMPLE_WIDTH  tracked +2 level
- gain  out  8  current AGC gain
- locked  out  1  AGC locked
- state  out  2  00=IDLE, 01=ACQUIRE, 10=TRACK

Behaviour:
- Clocking and reset: one clock, clk. reset_n is asynchronous and active-low.
- Reset values:
  - sample_out=0, sample_valid=0, decision_out=00.
  - gain=GAIN_INIT, level_pos2=TARGET, level_neg2=-TARGET, level_zero=0.
  - locked=0, state=IDLE, window counter=0, peak=0, lock counter=0.
- Pipeline (2 cycles; sample_valid is high exactly 2 cycles after each data_valid, with no bubbles and no stalls):
  - Stage 1 registers product = data_in × {0,gain}, signed 21-bit, using the gain register value in that cycle.
  - Stage 2 computes product >>> 8 (arithmetic), saturates to [-512,511], and registers sample_out and decision_out.
- Slicer thresholds:
  - thr_hi = (level_zero+level_pos2)>>>1 and thr_lo = (level_neg2+level_zero)>>>1, computed in 11-bit.
  - Decision is +2 if sample >= thr_hi, -2 if sample < thr_lo, else 0.
  - Decision is made on the saturated sample.
- Level tracking, on each output sample with freeze=0 and state≠IDLE:
  - The level selected by the decision updates as L <= L + ((s - L) >>> LEVEL_SHIFT), computed in 11-bit signed, then saturated.
- AGC window:
  - Each output sample updates peak = max(peak, |s|); |−512| = 512 in an 11-bit register.
  - On the WINDOW-th sample, evaluate the window including that sample. Gain and state update the following cycle; peak and count clear.
  - Evaluation rules:
    - peak > TARGET+DEADBAND: gain -= step.
    - peak < TARGET-DEADBAND: gain += step.
    - otherwise in-band, and gain is unchanged.
  - step = 4 in ACQUIRE, 1 in TRACK.
  - Gain saturates to [16,255].
  - A gain change applies to data entering stage 1 from the cycle after the update. Samples already in the pipeline keep the old gain.
- State machine:
  - IDLE -> ACQUIRE when enable=1.
  - ACQUIRE: an in-band window increments the lock counter; an out-of-band window clears it. When the counter reaches LOCK_WINDOWS, go to TRACK and set locked=1 in the same cycle.
  - TRACK: a window with |peak-TARGET| > 2×DEADBAND goes to ACQUIRE, clears locked and clears the lock counter.
  - Any state -> IDLE when enable=0. Effects:
    - Pipeline valids flushed the next cycle.
    - Window, peak and lock counter cleared; locked=0.
    - gain and levels retained.
  - data_valid is ignored in IDLE.
- freeze=1: gain, levels, window and lock counters hold. The datapath and decisions continue.
- Asynchronous reset mid-window discards all partial state.

Test Plan:
- Reset values: assert reset_n=0 -> gain=64, level_pos2=256, level_neg2=-256, level_zero=0, sample_valid=0, locked=0, state=00.
- Latency and scaling: enable=1, freeze=1, data_in=1024 valid -> 2 cycles later sample_out=256, decision=01. data_in=-2048 -> -512, decision=11. data_in=100 -> 25, decision=00.
- Saturation: GAIN_INIT=128, freeze=1, data_in=2047 -> sample_out=511. data_in=-2048 -> -512.
- Acquisition: alternating ±512, freeze=0 -> gain steps +4 per 32-sample window for windows 1..14 reaching 120 (output ±240). Windows 15–18 are in-band; locked=1 and state=10 after window 18. level_pos2 and level_neg2 converge to within ±8 of ±240.
- Loss of lock: after lock, input drops to ±128 (output ±60) -> at the end of the next window state=01 and locked=0; gain rises by 4 per window thereafter.
- Enable drop mid-window: after 10 samples deassert enable -> sample_valid=0 within 2 cycles, state=00, gain retained. Re-enable -> ACQUIRE, and the first window completes exactly 32 samples later.
